store_buffer_mc: RTL and testbench

//  Next-generation store buffer for the memory system. Parametrised depth and commit width (COMMIT_W stores retired/cycle).

---
 rtl/store_buffer_mc.sv | 167 ++++++++++++++++
 tb/tb_store_buffer_mc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_mc.sv
// Store buffer: one circular queue of committed + speculative stores, byte-merged
// load forwarding, and a dcache drain port.
// Ports: AGU enqueue (enq_*), ROB completion (ins_*), ROB commit/flush,
//   load-queue conflict search (conflict_*), dcache store port (store_*, cache_done_i), status.
// Latency: ins_cmp_o arrives 1 cycle after acceptance. Forwarding and the drain port are combinational.
// Backpressure: enq_full_o comes from registered state only. The drain entry is held until cache_done_i.
// Optional: define STB_COALESCE_EN to merge two same-address committed head entries into one dcache write.
module store_buffer_mc #(
  parameter int PHYS     = 32,
  parameter int ENTRIES  = 8,
  parameter int COMMIT_W = 2,
  parameter int ROB_W    = 5
) (
  input  logic                cpu_clk_i,
  input  logic                cpu_rst_ni,
  input  logic                flush_i,
  input  logic                enq_valid_i,
  input  logic [PHYS-3:0]     enq_address_i,
  input  logic [31:0]         enq_data_i,
  input  logic [3:0]          enq_bm_i,
  input  logic                enq_io_i,
  input  logic [ROB_W-1:0]    enq_rob_i,
  output logic                enq_full_o,
  output logic                ins_cmp_o,
  output logic [ROB_W-1:0]    ins_rob_o,
  input  logic [COMMIT_W-1:0] commit_i,
  input  logic [PHYS-3:0]     conflict_address_i,
  input  logic [3:0]          conflict_bm_i,
  output logic [31:0]         conflict_data_o,
  output logic [3:0]          conflict_bm_o,
  output logic                conflict_res_valid_o,
  output logic                conflict_resolvable_o,
  output logic                store_valid_o,
  output logic [PHYS-3:0]     store_address_o,
  output logic [31:0]         store_data_o,
  output logic [3:0]          store_bm_o,
  output logic                store_io_o,
  input  logic                cache_done_i,
  output logic                empty_o
);

  localparam int AW = PHYS - 2;
  localparam int IW = $clog2(ENTRIES);
  localparam int PW = IW + 1;

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [PW-1:0] head_q, cmt_q, tail_q;
  logic [AW-1:0] addr_q [ENTRIES];
  logic [31:0]   data_q [ENTRIES];
  logic [3:0]    bm_q   [ENTRIES];
  logic          io_q   [ENTRIES];

  logic             ins_cmp_q;
  logic [ROB_W-1:0] ins_rob_q;

  logic [PW-1:0] used_cnt, spec_cnt, cmt_cnt, commit_cnt, cmt_nxt, head_step;
  logic [IW-1:0] h0, h1, fi;
  logic [PW-1:0] fwd_idx;
  logic          enq_acc, drain_fire, io_hit;

  always_comb begin
    commit_cnt = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      commit_cnt = commit_cnt + PW'(commit_i[i]);
    end
  end

  assign used_cnt   = tail_q - head_q;
  assign spec_cnt   = tail_q - cmt_q;
  assign cmt_cnt    = cmt_q - head_q;
  assign cmt_nxt    = cmt_q + commit_cnt;
  assign enq_full_o = (used_cnt == PW'(ENTRIES));
  assign empty_o    = (tail_q == head_q);
  assign enq_acc    = enq_valid_i & ~enq_full_o & ~flush_i;
  assign ins_cmp_o  = ins_cmp_q;
  assign ins_rob_o  = ins_rob_q;

  // Drain port: the committed entry at head.
  assign h0            = head_q[IW-1:0];
  assign h1            = h0 + IW'(1);
  assign store_valid_o = (cmt_cnt != '0);
  assign drain_fire    = cache_done_i & store_valid_o;

`ifdef STB_COALESCE_EN
  logic coalesce;
  assign coalesce = (cmt_cnt >= PW'(2)) & ~io_q[h0] & ~io_q[h1] & (addr_q[h0] == addr_q[h1]);
`endif

  always_comb begin
    store_address_o = addr_q[h0];
    store_data_o    = data_q[h0];
    store_bm_o      = bm_q[h0];
    store_io_o      = io_q[h0];
    head_step       = PW'(1);
`ifdef STB_COALESCE_EN
    if (coalesce) begin
      // The younger entry's bytes override the older one's.
      store_bm_o = bm_q[h0] | bm_q[h1];
      for (int b = 0; b < 4; b++) begin
        if (bm_q[h1][b]) store_data_o[8*b +: 8] = data_q[h1][8*b +: 8];
      end
      head_step = PW'(2);
    end
`endif
  end

  // Forwarding: walk from oldest to youngest so that younger bytes overwrite older ones.
  always_comb begin
    conflict_data_o      = '0;
    conflict_bm_o        = '0;
    conflict_res_valid_o = 1'b0;
    io_hit               = 1'b0;
    fwd_idx              = '0;
    fi                   = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      fwd_idx = head_q + PW'(k);
      fi      = fwd_idx[IW-1:0];
      if ((PW'(k) < used_cnt) && (addr_q[fi] == conflict_address_i)) begin
        conflict_res_valid_o = 1'b1;
        if (io_q[fi]) begin
          io_hit = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (bm_q[fi][b]) begin
              conflict_data_o[8*b +: 8] = data_q[fi][8*b +: 8];
              conflict_bm_o[b]          = 1'b1;
            end
          end
        end
      end
    end
  end

  assign conflict_resolvable_o = conflict_res_valid_o & ~io_hit &
                                 ((conflict_bm_i & ~conflict_bm_o) == 4'h0);

  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rst_ni) begin
      head_q    <= '0;
      cmt_q     <= '0;
      tail_q    <= '0;
      ins_cmp_q <= 1'b0;
      ins_rob_q <= '0;
    end else begin
      if (drain_fire) head_q <= head_q + head_step;
      cmt_q <= cmt_nxt;
      // Flush drops every speculative entry, including any that commit has not reached.
      if (flush_i)      tail_q <= cmt_nxt;
      else if (enq_acc) tail_q <= tail_q + PW'(1);
      ins_cmp_q <= enq_acc;
      if (enq_acc) ins_rob_q <= enq_rob_i;
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (enq_acc) begin
      addr_q[tail_q[IW-1:0]] <= enq_address_i;
      data_q[tail_q[IW-1:0]] <= enq_data_i;
      bm_q[tail_q[IW-1:0]]   <= enq_bm_i;
      io_q[tail_q[IW-1:0]]   <= enq_io_i;
    end
  end

  // The ROB may only retire stores that are actually speculative in the buffer.
  assert property (@(posedge cpu_clk_i) disable iff (!cpu_rst_ni) commit_cnt <= spec_cnt);

endmodule

// File: tb/tb_store_buffer_mc.sv
module tb_store_buffer_mc;

  logic        clk = 1'b0;
  logic        rst_n, flush, enq_valid, enq_io, cache_done;
  logic [29:0] enq_addr, conf_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_bm, conf_bm;
  logic [4:0]  enq_rob;
  logic [1:0]  commit;
  logic        enq_full, ins_cmp, res_valid, resolvable, store_valid, store_io, empty;
  logic [4:0]  ins_rob;
  logic [31:0] conf_data, store_data;
  logic [3:0]  conf_bm_o, store_bm;
  logic [29:0] store_addr;

  store_buffer_mc dut (
    .cpu_clk_i(clk), .cpu_rst_ni(rst_n), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_address_i(enq_addr), .enq_data_i(enq_data),
    .enq_bm_i(enq_bm), .enq_io_i(enq_io), .enq_rob_i(enq_rob),
    .enq_full_o(enq_full), .ins_cmp_o(ins_cmp), .ins_rob_o(ins_rob),
    .commit_i(commit), .conflict_address_i(conf_addr), .conflict_bm_i(conf_bm),
    .conflict_data_o(conf_data), .conflict_bm_o(conf_bm_o),
    .conflict_res_valid_o(res_valid), .conflict_resolvable_o(resolvable),
    .store_valid_o(store_valid), .store_address_o(store_addr), .store_data_o(store_data),
    .store_bm_o(store_bm), .store_io_o(store_io), .cache_done_i(cache_done), .empty_o(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        io;
  } ent_t;

  // Model: queue in age order; the first ncmt entries are committed.
  ent_t       q[$];
  int         ncmt;
  logic       exp_ins;
  logic [4:0] exp_rob;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit coal_now();
`ifdef STB_COALESCE_EN
    return ncmt >= 2 && !q[0].io && !q[1].io && q[0].a == q[1].a;
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock: the model consumes the same inputs the DUT samples.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      ncmt    = 0;
      exp_ins = 1'b0;
      exp_rob = '0;
    end else begin
      bit acc;
      int n;
      acc = enq_valid && q.size() < 8 && !flush;
      if (cache_done && ncmt > 0) begin
        n = coal_now() ? 2 : 1;
        repeat (n) void'(q.pop_front());
        ncmt -= n;
      end
      ncmt += int'(commit[0]) + int'(commit[1]);
      if (flush) while (q.size() > ncmt) void'(q.pop_back());
      if (acc) q.push_back('{a: enq_addr, d: enq_data, m: enq_bm, io: enq_io});
      exp_ins = acc;
      if (acc) exp_rob = enq_rob;
    end
    #1;
  endtask

  task automatic idle_in();
    flush = 0; enq_valid = 0; enq_io = 0; cache_done = 0; commit = 0;
    enq_addr = 0; enq_data = 0; enq_bm = 0; enq_rob = 0; conf_addr = 0; conf_bm = 0;
  endtask

  task automatic enq(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic io, input logic [4:0] rob);
    enq_valid = 1; enq_addr = a; enq_data = d; enq_bm = m; enq_io = io; enq_rob = rob;
    step();
    enq_valid = 0; enq_io = 0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [31:0] fd, sd;
      logic [3:0]  fm, sm;
      logic        rv, ioh;
      fd = 0; fm = 0; rv = 0; ioh = 0;
      foreach (q[i]) begin
        if (q[i].a == conf_addr) begin
          rv = 1;
          if (q[i].io) ioh = 1;
          else for (int b = 0; b < 4; b++) if (q[i].m[b]) begin
            fm[b] = 1;
            fd[8*b +: 8] = q[i].d[8*b +: 8];
          end
        end
      end
      chk("full", {31'b0, enq_full}, {31'b0, q.size() == 8});
      chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
      chk("store_valid", {31'b0, store_valid}, {31'b0, ncmt > 0});
      chk("ins_cmp", {31'b0, ins_cmp}, {31'b0, exp_ins});
      if (exp_ins) chk("ins_rob", {27'b0, ins_rob}, {27'b0, exp_rob});
      chk("res_valid", {31'b0, res_valid}, {31'b0, rv});
      chk("resolvable", {31'b0, resolvable}, {31'b0, rv && !ioh && ((conf_bm & ~fm) == 0)});
      chk("fwd_bm", {28'b0, conf_bm_o}, {28'b0, fm});
      for (int b = 0; b < 4; b++) if (fm[b])
        chk("fwd_byte", {24'b0, conf_data[8*b +: 8]}, {24'b0, fd[8*b +: 8]});
      if (ncmt > 0) begin
        sd = q[0].d; sm = q[0].m;
        if (coal_now()) begin
          sm = q[0].m | q[1].m;
          for (int b = 0; b < 4; b++) if (q[1].m[b]) sd[8*b +: 8] = q[1].d[8*b +: 8];
        end
        chk("store_addr", {2'b0, store_addr}, {2'b0, q[0].a});
        chk("store_bm", {28'b0, store_bm}, {28'b0, sm});
        chk("store_io", {31'b0, store_io}, {31'b0, q[0].io});
        for (int b = 0; b < 4; b++) if (sm[b])
          chk("store_byte", {24'b0, store_data[8*b +: 8]}, {24'b0, sd[8*b +: 8]});
      end
    end
  end

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    at_neg();
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, enq_full}, 32'd0);
    chk("rst_store_valid", {31'b0, store_valid}, 32'd0);
    chk("rst_ins_cmp", {31'b0, ins_cmp}, 32'd0);
    chk("rst_ins_rob", {27'b0, ins_rob}, 32'd0);

    // First store: completion one cycle later, drains only after commit.
    enq(30'h100, 32'hDEADBEEF, 4'hF, 0, 5'd3);
    at_neg();
    chk("t1_ins_cmp", {31'b0, ins_cmp}, 32'd1);
    chk("t1_ins_rob", {27'b0, ins_rob}, 32'd3);
    chk("t1_empty", {31'b0, empty}, 32'd0);
    chk("t1_sv_before", {31'b0, store_valid}, 32'd0);
    step();
    commit = 2'b01; step(); commit = 0;
    at_neg();
    chk("t1_sv_after", {31'b0, store_valid}, 32'd1);
    chk("t1_saddr", {2'b0, store_addr}, 32'h100);
    chk("t1_sdata", store_data, 32'hDEADBEEF);
    cache_done = 1; step(); cache_done = 0;
    at_neg();
    chk("t1_empty_end", {31'b0, empty}, 32'd1);

    // Fill, drop the ninth store, then free one slot.
    for (int i = 0; i < 8; i++) enq(30'h200 + 30'(i), 32'(i), 4'hF, 0, 5'(i));
    at_neg();
    chk("t2_full", {31'b0, enq_full}, 32'd1);
    enq(30'h2FF, 32'h99, 4'hF, 0, 5'd31);
    at_neg();
    chk("t2_dropped_ins", {31'b0, ins_cmp}, 32'd0);
    commit = 2'b11; repeat (4) step(); commit = 0;
    cache_done = 1; step(); cache_done = 0;
    at_neg();
    chk("t2_freed", {31'b0, enq_full}, 32'd0);
    cache_done = 1; repeat (7) step(); cache_done = 0;
    at_neg();
    chk("t2_empty", {31'b0, empty}, 32'd1);

    // Byte-merged forwarding from two stores to the same word.
    enq(30'h40, 32'h00001111, 4'h3, 0, 5'd1);
    enq(30'h40, 32'h00222200, 4'h6, 0, 5'd2);
    step();
    conf_addr = 30'h40; conf_bm = 4'hF;
    at_neg();
    chk("t3_data", {8'h0, conf_data[23:0]}, 32'h222211);
    chk("t3_bm", {28'b0, conf_bm_o}, 32'h7);
    chk("t3_resolvable", {31'b0, resolvable}, 32'd0);
    flush = 1; step(); flush = 0;
    at_neg();
    chk("t3_flushed", {31'b0, empty}, 32'd1);

    // Flush after committing two of four.
    for (int i = 0; i < 4; i++) enq(30'h300 + 30'(i), 32'hA0 + 32'(i), 4'hF, 0, 5'(i));
    commit = 2'b11; step(); commit = 0;
    flush = 1; step(); flush = 0;
    at_neg();
    chk("t4_saddr0", {2'b0, store_addr}, 32'h300);
    cache_done = 1; step();
    at_neg();
    chk("t4_saddr1", {2'b0, store_addr}, 32'h301);
    step(); cache_done = 0;
    at_neg();
    chk("t4_empty", {31'b0, empty}, 32'd1);

    // IO store is detected but never forwarded.
    enq(30'h80, 32'hAAAA5555, 4'hF, 1, 5'd7);
    step();
    conf_addr = 30'h80; conf_bm = 4'hF;
    at_neg();
    chk("t5_res_valid", {31'b0, res_valid}, 32'd1);
    chk("t5_resolvable", {31'b0, resolvable}, 32'd0);
    chk("t5_bm", {28'b0, conf_bm_o}, 32'd0);
    flush = 1; step(); flush = 0;

    // Two committed same-word stores at head.
    enq(30'h10, 32'h000000AA, 4'h1, 0, 5'd1);
    enq(30'h10, 32'hBB000000, 4'h8, 0, 5'd2);
    commit = 2'b11; step(); commit = 0;
    at_neg();
`ifdef STB_COALESCE_EN
    chk("t6_bm", {28'b0, store_bm}, 32'h9);
    chk("t6_data", store_data, 32'hBB0000AA);
    cache_done = 1; step(); cache_done = 0;
`else
    chk("t6_bm", {28'b0, store_bm}, 32'h1);
    cache_done = 1; step(); step(); cache_done = 0;
`endif
    at_neg();
    chk("t6_empty", {31'b0, empty}, 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int spec;
      logic [29:0] addrs [4];
      addrs[0] = 30'h40; addrs[1] = 30'h41; addrs[2] = 30'h80; addrs[3] = 30'h100;
      enq_valid = ($urandom % 3) != 0;
      enq_addr  = addrs[$urandom_range(0, 3)];
      enq_data  = $urandom;
      enq_bm    = 4'($urandom_range(0, 15));
      enq_io    = ($urandom % 10) == 0;
      enq_rob   = 5'($urandom);
      spec      = q.size() - ncmt;
      commit    = 2'($urandom);
      if (spec == 0) commit = 0;
      else if (spec == 1 && commit == 2'b11) commit = 2'b10;
      flush      = (($urandom % 25) == 0) && !exp_ins;
      cache_done = 1'($urandom);
      conf_addr  = addrs[$urandom_range(0, 3)];
      conf_bm    = 4'($urandom_range(0, 15));
      step();
    end
    idle_in();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
